// File: rtl/mem_target.sv
// Word-addressed RAM plus a small MMIO window (GPIO, cycle counter, scratch)
// behind the CPU memory port, with a configurable registered read latency.
module mem_target #(
  parameter int          DEPTH      = 1024,
  parameter int          RD_LATENCY = 1,
  parameter string       INIT_FILE  = "",
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic [15:0] addr,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [7:0]  gpio_out,
  output logic        bus_err
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH) << 2;
  localparam logic [15:0] GPIO_A    = MMIO_BASE;
  localparam logic [15:0] CYC_A     = MMIO_BASE + 16'h0004;
  localparam logic [15:0] SCR_A     = MMIO_BASE + 16'h0008;
  localparam logic [2:0]  LAT_M1    = 3'(RD_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [2:0] {R_RAM, R_GPIO, R_CYC, R_SCR, R_BAD} region_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] ram [DEPTH];
  logic [15:0] lat_addr_p0;
  logic [31:0] ram_q_p1;
  logic [31:0] mmio_q_p1;
  logic        sel_ram_p1;
  logic [7:0]  gpio;
  logic [31:0] scratch;
  logic [31:0] cycles;

  logic        accept;
  logic        load;
  logic [15:0] src_addr;
  region_t     src_rgn;
  region_t     wr_rgn;

  function automatic region_t decode(input logic [15:0] a);
    logic [15:0] w;
    w = a & 16'hFFFC;
    if ({16'd0, a} < RAM_BYTES) return R_RAM;
    if (w == GPIO_A) return R_GPIO;
    if (w == CYC_A) return R_CYC;
    if (w == SCR_A) return R_SCR;
    return R_BAD;
  endfunction

  function automatic logic [31:0] mmio_word(input region_t r, input logic [7:0] g,
                                            input logic [31:0] c, input logic [31:0] s);
    case (r)
      R_GPIO:  return {24'd0, g};
      R_CYC:   return c;
      R_SCR:   return s;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // load marks the edge that enters RESP: data is sampled here, not at accept,
  // so writes landing during WAIT are seen by the pending read.
  always_comb begin
    accept   = rd_en && !wr_en && (state == IDLE || state == RESP);
    load     = (accept && RD_LATENCY == 1) || (state == WAIT && cnt == 3'd1);
    src_addr = (state == WAIT) ? lat_addr_p0 : addr;
    src_rgn  = decode(src_addr);
    wr_rgn   = decode(addr);
  end

  // p0: request address capture; p1: RAM word sampled on RESP entry
  always_ff @(posedge clk) begin
    if (wr_en && wr_rgn == R_RAM) ram[addr[AW+1:2]] <= wr_data;
    if (load) ram_q_p1 <= ram[src_addr[AW+1:2]];
    if (accept) lat_addr_p0 <= addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      rd_valid   <= 1'b0;
      sel_ram_p1 <= 1'b0;
      mmio_q_p1  <= 32'd0;
      gpio       <= 8'd0;
      scratch    <= 32'd0;
      cycles     <= 32'd0;
      bus_err    <= 1'b0;
    end else begin
      cycles   <= cycles + 32'd1;
      rd_valid <= load;
      if (load) begin
        sel_ram_p1 <= (src_rgn == R_RAM);
        mmio_q_p1  <= mmio_word(src_rgn, gpio, cycles, scratch);
      end
      if (wr_en) begin
        case (wr_rgn)
          R_GPIO:  gpio    <= wr_data[7:0];
          R_SCR:   scratch <= wr_data;
          default: ;
        endcase
      end
      if ((wr_en && wr_rgn == R_BAD) || (load && src_rgn == R_BAD)) bus_err <= 1'b1;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            cnt   <= LAT_M1;
            state <= (RD_LATENCY == 1) ? RESP : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_data  = sel_ram_p1 ? ram_q_p1 : mmio_q_p1;
  assign gpio_out = gpio;

endmodule

// File: tb/tb_mem_target.sv
// Randomized scoreboard bench for mem_target at read latencies 1 and 3.
module tb_mem_target;

  localparam logic [15:0] MB = 16'hFF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {int kind; logic [15:0] addr; logic [31:0] data;} txn_t;
  typedef struct {int edge_n; logic [31:0] data;} rsp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, want, ecnt);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst_n, rd_en, wr_en, rd_valid, bus_err;
    logic [15:0] addr;
    logic [31:0] wr_data, rd_data;
    logic [7:0]  gpio_out;
    logic        done_g = 1'b0;

    mem_target #(.DEPTH(1024), .RD_LATENCY(LAT), .INIT_FILE(""), .MMIO_BASE(MB)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .rd_data(rd_data),
      .rd_valid(rd_valid), .wr_en(wr_en), .wr_data(wr_data), .gpio_out(gpio_out),
      .bus_err(bus_err));

    // Reference model: address map as plain storage, one outstanding read.
    logic [31:0] mem [1024];
    logic [7:0]  m_gpio;
    logic [31:0] m_scr, m_cyc;
    logic        m_err;
    bit          pend;
    logic [15:0] pend_addr;
    int          pend_edge;
    rsp_t        exp_q[$];
    txn_t        tq[$];

    function automatic bit unmapped(input logic [15:0] a);
      logic [15:0] w;
      w = a & 16'hFFFC;
      return !(a < 16'h1000) && w != MB && w != MB + 16'h4 && w != MB + 16'h8;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
      logic [15:0] w;
      w = a & 16'hFFFC;
      if (a < 16'h1000) return mem[w[11:2]];
      if (w == MB) return {24'd0, m_gpio};
      if (w == MB + 16'h4) return m_cyc;
      if (w == MB + 16'h8) return m_scr;
      return 32'hDEADBEEF;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [31:0] d);
      logic [15:0] w;
      w = a & 16'hFFFC;
      if (a < 16'h1000) mem[w[11:2]] = d;
      else if (w == MB) m_gpio = d[7:0];
      else if (w == MB + 16'h8) m_scr = d;
      else if (w != MB + 16'h4) m_err = 1'b1;
    endtask

    task automatic model_reset();
      m_gpio = 8'd0; m_scr = 32'd0; m_cyc = 32'd0; m_err = 1'b0; pend = 1'b0;
    endtask

    task automatic finalize(input int e);
      exp_q.push_back('{e, model_read(pend_addr)});
      if (unmapped(pend_addr)) m_err = 1'b1;
      pend = 1'b0;
    endtask

    function automatic logic [15:0] pick_addr();
      int unsigned r;
      logic [15:0] base;
      r = $urandom_range(0, 99);
      if (r < 66) base = 16'($urandom_range(0, 63) * 4);
      else if (r < 76) base = MB;
      else if (r < 84) base = MB + 16'h4;
      else if (r < 93) base = MB + 16'h8;
      else begin
        case ($urandom_range(0, 3))
          0: base = 16'hF000;
          1: base = MB + 16'h000C;
          2: base = 16'h1000;
          default: base = 16'hFFFC;
        endcase
      end
      return base | 16'($urandom_range(0, 3));
    endfunction

    // Driver: acts 2 time units after each rising edge, first applying that
    // edge's effects to the model, then choosing inputs for the next edge.
    initial begin
      int  hold;
      bit  reading;
      bit  resp_now;
      bit  was_p;
      int  e;
      txn_t cur;
      rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 16'd0; wr_data = 32'd0;
      model_reset();
      hold = 3; reading = 1'b0; cur = '{0, 16'd0, 32'd0};
      for (int w = 0; w < 64; w++)
        tq.push_back('{2, 16'(w * 4), (w == 32) ? 32'h00000013 : $urandom()});
      tq.push_back('{1, 16'h0080, 32'd0});
      tq.push_back('{1, 16'h0008, 32'd0});
      tq.push_back('{0, 16'h0000, 32'd0});
      tq.push_back('{2, MB, 32'h0000A5A5});
      tq.push_back('{1, MB, 32'd0});
      tq.push_back('{2, 16'h0010, 32'h12345678});
      tq.push_back('{1, 16'h0010, 32'd0});
      tq.push_back('{1, MB + 16'h4, 32'd0});
      for (int i = 0; i < 5; i++) tq.push_back('{0, 16'h0000, 32'd0});
      tq.push_back('{1, MB + 16'h4, 32'd0});
      tq.push_back('{1, 16'hF000, 32'd0});
      tq.push_back('{3, 16'h0020, 32'hCAFEF00D});
      tq.push_back('{0, 16'h0000, 32'd0});
      tq.push_back('{4, 16'h0040, 32'd0});
      tq.push_back('{0, 16'h0000, 32'd0});
      tq.push_back('{5, 16'h0000, 32'd0});
      tq.push_back('{1, MB + 16'h4, 32'd0});
      tq.push_back('{1, MB, 32'd0});
      tq.push_back('{1, MB + 16'h8, 32'd0});
      tq.push_back('{1, 16'h0020, 32'd0});
      for (int i = 0; i < 250; i++) begin
        int unsigned k;
        k = $urandom_range(0, 99);
        tq.push_back('{(k < 50) ? 1 : (k < 80) ? 2 : (k < 86) ? 3 : 0, pick_addr(), $urandom()});
      end

      while (1) begin
        @(posedge clk);
        #2;
        e = ecnt;
        if (!rst_n) begin
          hold--;
          if (hold == 0) rst_n = 1'b1;
          continue;
        end
        resp_now = 1'b0;
        was_p = pend;
        if (pend && pend_edge == e) begin finalize(e); resp_now = 1'b1; end
        if (!was_p && rd_en && !wr_en) begin
          pend = 1'b1; pend_addr = addr; pend_edge = e + LAT - 1;
          if (LAT == 1) begin finalize(e); resp_now = 1'b1; end
        end
        if (wr_en) model_write(addr, wr_data);
        m_cyc = m_cyc + 32'd1;

        wr_en = 1'b0;
        if (reading && !resp_now) begin
          if (pend && cur.kind == 4) begin
            rst_n = 1'b0; hold = 3; model_reset(); rd_en = 1'b0; reading = 1'b0;
          end else if (pend) begin
            addr = pick_addr();
            if ($urandom_range(0, 2) == 0) begin
              wr_en = 1'b1; wr_data = $urandom();
              if ($urandom_range(0, 1) == 1) addr = pend_addr;
            end
          end else begin
            addr = cur.addr;
          end
        end else begin
          reading = 1'b0; rd_en = 1'b0;
          if (tq.size() == 0) break;
          cur = tq.pop_front();
          case (cur.kind)
            1, 4: begin rd_en = 1'b1; addr = cur.addr; reading = 1'b1; end
            2: begin wr_en = 1'b1; addr = cur.addr; wr_data = cur.data; end
            3: begin
              rd_en = 1'b1; wr_en = 1'b1; addr = cur.addr; wr_data = cur.data; reading = 1'b1;
            end
            5: begin rst_n = 1'b0; hold = 3; model_reset(); end
            default: ;
          endcase
        end
      end
      rd_en = 1'b0; wr_en = 1'b0;
      repeat (LAT + 3) @(posedge clk);
      chk($sformatf("L%0d drain", LAT), 32'(exp_q.size()), 32'd0);
      done_g = 1'b1;
    end

    // Monitor: checks every falling edge against the model and the response queue.
    initial begin
      rsp_t r;
      @(posedge clk);
      forever begin
        @(negedge clk);
        chk($sformatf("L%0d gpio_out", LAT), {24'd0, gpio_out}, {24'd0, m_gpio});
        chk($sformatf("L%0d bus_err", LAT), {31'd0, bus_err}, {31'd0, m_err});
        if (!rst_n) begin
          chk($sformatf("L%0d reset rd_valid", LAT), {31'd0, rd_valid}, 32'd0);
          chk($sformatf("L%0d reset rd_data", LAT), rd_data, 32'd0);
        end else if (rd_valid) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL L%0d unexpected rd_valid: got 1, expected 0 (edge %0d)", LAT, ecnt);
          end else begin
            r = exp_q.pop_front();
            chk($sformatf("L%0d rd_valid edge", LAT), 32'(ecnt), 32'(r.edge_n));
            chk($sformatf("L%0d rd_data", LAT), rd_data, r.data);
          end
        end else if (exp_q.size() > 0 && exp_q[0].edge_n <= ecnt) begin
          r = exp_q.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL L%0d missing rd_valid: got 0, expected 1 with %h (edge %0d)",
                   LAT, r.data, r.edge_n);
        end
      end
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (!(inst[0].done_g && inst[1].done_g) && waited < 50000) begin
      @(posedge clk);
      waited++;
    end
    if (!(inst[0].done_g && inst[1].done_g)) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: done flags %b%b, expected 11", inst[1].done_g, inst[0].done_g);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
